jtag_shift_master: RTL and testbench
====================================

# jtag_shift_master

Parametrised, synthesizable JTAG bit-bang master that replaces the host-driven JTAG DPI path in the Azadi Verilator harness. It drives the SoC's `jtag_tck_i`/`jtag_tms_i`/`jtag_tdi_i`/`jtag_trst_ni` and samples `jtag_tdo_o`. Command requests arrive over a valid/ready interface: IR scan, DR scan, or TAP reset, each of up to `MaxLen` bits. The block generates a divided TCK, walks the IEEE 1149.1 TAP state machine, and returns captured TDO data over a valid/ready response.

## Interface
- `MaxLen`, 64: maximum scan length in bits (≥2).
- `ClkDiv`, 2: system cycles per TCK half-period (≥1).
- `LenW`, `$clog2(MaxLen+1)`: width of the length field (derived).

Ports:
- `clock_i`  in  1  system clock; all logic on its rising edge.
- `reset_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  1  command valid.
- `req_ready_o`  out  1  command accepted when both valid and ready are high.
- `req_op_i`  in  2  command: 0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (error).
- `req_len_i`  in  LenW  scan length in bits.
- `req_tdi_i`  in  MaxLen  TDI data, bit 0 shifted first.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_tdo_o`  out  MaxLen  captured TDO, bit 0 captured first; bits ≥ len are 0.
- `rsp_err_o`  out  1  command rejected (bad op or length).
- `jtag_tck_o`, `jtag_tms_o`, `jtag_tdi_o`, `jtag_trst_no`  out  1 each  JTAG drive.
- `jtag_tdo_i`  in  1  JTAG return.

## Operation
- **FSM states:** AUTO_RST, IDLE, RESET, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RTI, RESP.
- **Step:** one TCK period of 2·ClkDiv cycles.
  - Low phase: TCK=0 for ClkDiv cycles; TMS and TDI update on its first cycle.
  - High phase: TCK=1 for ClkDiv cycles; TDO is sampled on its first cycle.
- **After reset release:** the block enters AUTO_RST and runs the reset sequence. `req_ready_o` stays 0 until that sequence completes.
- **RESET / AUTO_RST sequence:** 6 steps, TMS = 1,1,1,1,1,0. The TAP ends in Run-Test/Idle. `jtag_trst_no` = 0 during steps 0–4 and 1 from step 5. For op 2, `rsp_tdo_o` = 0 and `rsp_err_o` = 0.
- **DR scan** (L bits), TMS sequence per step:
  - 1 (Select-DR), 0 (Capture), 0 (enter Shift).
  - L shift steps: TMS=0 for bits 0..L-2, TMS=1 on bit L-1 (exit to Exit1).
  - 1 (Update), 0 (Run-Test/Idle).
  - Total steps: L+5.
- **IR scan:** an extra TMS=1 step (Select-IR) after Select-DR. Total steps: L+6.
- **Shift steps:** TDI = `req_tdi_i[i]` is latched at accept and held per step. TDO from step i's sample goes into `rsp_tdo_o[i]`.
- **Non-shift steps:** TDI = 0.
- **Error conditions:** `req_len_i` = 0, `req_len_i` > MaxLen, or op 3, for op 0 or 1. No TCK activity occurs. The block goes to RESP with `rsp_err_o` = 1 and `rsp_tdo_o` = 0.
- **Request handshake:** `req_ready_o` = 1 only in IDLE. All request fields are registered on accept.
- **Response handshake:**
  - In RESP, `rsp_valid_o` = 1 and the data holds stable until `rsp_ready_i`.
  - Return to IDLE on the cycle after the handshake.
  - `rsp_ready_i` while not valid is ignored.
- **Idle outputs:** TCK=0, TMS=0, TDI=0, TRST_N=1.

## Timing
- **Reset values:** `jtag_tck_o` 0, `jtag_tms_o` 1, `jtag_tdi_o` 0, `jtag_trst_no` 0, `req_ready_o` 0, `rsp_valid_o` 0, `rsp_tdo_o` 0, `rsp_err_o` 0.
- **Auto-reset timing:** AUTO_RST step 0 starts on the first clock after reset release. `req_ready_o` rises 6·2·ClkDiv + 1 cycles after release.
- **Scan latency:**
  - Accept on cycle 0. Step 0 begins on cycle 1.
  - `rsp_valid_o` rises on cycle 1 + S·2·ClkDiv, where S = L+5 (DR), L+6 (IR), or 6 (reset).
- **Error latency:** `rsp_valid_o` rises on cycle 1.
- **Length boundaries:** L = 1 means the single shift step carries TMS=1. L = MaxLen fills every `rsp_tdo_o` bit.
- **Back-to-back commands:** minimum 1 idle cycle between RESP handshake and the next accept. TCK stays 0 in between.
- **Asynchronous reset mid-scan:** all outputs go immediately to their reset values. Any pending response is dropped, and AUTO_RST restarts.
- **Step counter:** sized for MaxLen+6 steps. **Phase counter:** wraps at ClkDiv-1; no other wrap is permitted.

## Test plan
1. **Reset release:** release `reset_ni`; with ClkDiv=2, expect 6 TCK pulses, TMS = 1,1,1,1,1,0, TRST_N low for the first 5 periods, and `req_ready_o` high at cycle 25.
2. **IR scan against a TAP model:** IR scan, L=5, TDI=5'b00001 (IDCODE) → 11 TCK pulses, TMS = 1,1,0,0,0,0,0,0,1,1,0; `rsp_tdo_o[4:0]` = 5'b00001 (capture value); `rsp_valid_o` at cycle 1 + 11·4 = 45.
3. **DR scan of IDCODE:** DR scan, L=32, TDI=0 after the IDCODE IR → `rsp_tdo_o[31:0]` = 32'h04F5484D, upper bits 0, 37 TCK pulses.
4. **Length boundaries:** L=1 DR scan → 6 pulses with TMS=1 on the shift step. L=MaxLen with a bypass model → `rsp_tdo_o` = `req_tdi_i` shifted by one (bit 0 = 0).
5. **Errors and backpressure:** L=0, L=MaxLen+1, and op 3 → `rsp_err_o` = 1 at cycle 1, no TCK edges. Holding `rsp_ready_i` low for 10 cycles → response held stable and `req_ready_o` = 0 throughout.
6. **Reset mid-scan:** assert `reset_ni` low mid-scan (step 8 of a 32-bit DR scan) → outputs reach reset values within the same cycle; after release the AUTO_RST sequence repeats and the next scan returns correct IDCODE.

Source files
------------

// File: rtl/jtag_shift_master.sv
// JTAG bit-bang master: walks the 1149.1 TAP for IR/DR scans and TAP reset,
// generating a divided TCK and returning captured TDO over valid/ready.
module jtag_shift_master #(
    parameter int MaxLen = 64,
    parameter int ClkDiv = 2,
    parameter int LenW   = $clog2(MaxLen + 1)
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [LenW-1:0]   req_len_i,
    input  logic [MaxLen-1:0] req_tdi_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [MaxLen-1:0] rsp_tdo_o,
    output logic              rsp_err_o,
    output logic              jtag_tck_o,
    output logic              jtag_tms_o,
    output logic              jtag_tdi_o,
    output logic              jtag_trst_no,
    input  logic              jtag_tdo_i
);

    localparam int SW = $clog2(MaxLen + 6);
    localparam int PW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int IW = $clog2(MaxLen);

    localparam logic [PW-1:0] PhaseMax = PW'(ClkDiv - 1);
    localparam logic [SW-1:0] RstLast  = SW'(5);

    localparam logic [3:0] AUTO_RST = 4'd0;
    localparam logic [3:0] IDLE     = 4'd1;
    localparam logic [3:0] RESET    = 4'd2;
    localparam logic [3:0] SEL_DR   = 4'd3;
    localparam logic [3:0] SEL_IR   = 4'd4;
    localparam logic [3:0] CAPTURE  = 4'd5;
    localparam logic [3:0] SHIFT    = 4'd6;
    localparam logic [3:0] EXIT1    = 4'd7;
    localparam logic [3:0] UPDATE   = 4'd8;
    localparam logic [3:0] RTI      = 4'd9;
    localparam logic [3:0] RESP     = 4'd10;

    logic [3:0]        state_q, state_d;
    logic [SW-1:0]     step_q, step_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              half_q, half_d;
    logic              boot_q, boot_d;
    logic              ir_q, ir_d;
    logic              err_q, err_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [MaxLen-1:0] tdi_q, tdi_d;
    logic [MaxLen-1:0] tdo_q, tdo_d;

    logic step_end, sample, last_bit, running, bad_req;

    assign step_end = half_q && (phase_q == PhaseMax);
    assign sample   = half_q && (phase_q == '0);
    assign last_bit = step_q == (SW'(len_q) - SW'(1));
    assign running  = !boot_q && (state_q != IDLE) && (state_q != RESP);
    assign bad_req  = (req_op_i == 2'd3) ||
                      ((req_op_i != 2'd2) &&
                       ((req_len_i == '0) || (req_len_i > LenW'(MaxLen))));

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        half_d  = half_q;
        boot_d  = 1'b0;
        ir_d    = ir_q;
        err_d   = err_q;
        len_d   = len_q;
        tdi_d   = tdi_q;
        tdo_d   = tdo_q;

        // The first cycle after reset release is spent arming the counters
        if (running) begin
            if (phase_q == PhaseMax) begin
                phase_d = '0;
                half_d  = ~half_q;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end

        unique case (state_q)
            AUTO_RST, RESET: begin
                if (step_end) begin
                    if (step_q == RstLast) begin
                        step_d  = '0;
                        state_d = (state_q == AUTO_RST) ? IDLE : RESP;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            IDLE: begin
                if (req_valid_i) begin
                    ir_d   = req_op_i == 2'd1;
                    len_d  = req_len_i;
                    tdi_d  = req_tdi_i;
                    tdo_d  = '0;
                    err_d  = bad_req;
                    step_d = '0;
                    if (bad_req)                state_d = RESP;
                    else if (req_op_i == 2'd2)  state_d = RESET;
                    else                        state_d = RTI;
                end
            end
            RTI:     if (step_end) state_d = SEL_DR;
            SEL_DR:  if (step_end) state_d = ir_q ? SEL_IR : CAPTURE;
            SEL_IR:  if (step_end) state_d = CAPTURE;
            CAPTURE: if (step_end) state_d = SHIFT;
            SHIFT: begin
                if (sample) tdo_d[step_q[IW-1:0]] = jtag_tdo_i;
                if (step_end) begin
                    tdi_d = tdi_q >> 1;
                    if (last_bit) begin
                        step_d  = '0;
                        state_d = EXIT1;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
            end
            EXIT1:  if (step_end) state_d = UPDATE;
            UPDATE: if (step_end) state_d = RESP;
            RESP:   if (rsp_ready_i) state_d = IDLE;
            default: state_d = AUTO_RST;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= AUTO_RST;
            step_q  <= '0;
            phase_q <= '0;
            half_q  <= 1'b0;
            boot_q  <= 1'b1;
            ir_q    <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
            tdi_q   <= '0;
            tdo_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            half_q  <= half_d;
            boot_q  <= boot_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
            len_q   <= len_d;
            tdi_q   <= tdi_d;
            tdo_q   <= tdo_d;
        end
    end

    // Each FSM state names the TAP state occupied during that TCK step
    always_comb begin
        jtag_tck_o   = half_q;
        jtag_tms_o   = 1'b0;
        jtag_tdi_o   = 1'b0;
        jtag_trst_no = 1'b1;
        unique case (state_q)
            AUTO_RST, RESET: begin
                jtag_tms_o   = step_q != RstLast;
                jtag_trst_no = step_q == RstLast;
            end
            RTI, EXIT1: jtag_tms_o = 1'b1;
            SEL_DR:     jtag_tms_o = ir_q;
            SHIFT: begin
                jtag_tms_o = last_bit;
                jtag_tdi_o = tdi_q[0];
            end
            default: ;
        endcase
    end

    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_tdo_o   = tdo_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_jtag_shift_master.sv
// Directed bench for jtag_shift_master against a behavioural TAP
// with a 5-bit IR, a 32-bit IDCODE register and a bypass register.
module tb_jtag_shift_master;

    localparam int ML = 64;
    localparam int CD = 2;
    localparam int LW = 7;
    localparam logic [63:0] IDCODE = 64'h0000_0000_04F5_484D;

    localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3;
    localparam int T_SHDR = 4, T_E1DR = 5, T_PDR = 6, T_E2DR = 7;
    localparam int T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11;
    localparam int T_E1IR = 12, T_PIR = 13, T_E2IR = 14, T_UIR = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid_i = 1'b0;
    logic req_ready_o;
    logic [1:0] req_op_i = '0;
    logic [LW-1:0] req_len_i = '0;
    logic [ML-1:0] req_tdi_i = '0;
    logic rsp_valid_o;
    logic rsp_ready_i = 1'b0;
    logic [ML-1:0] rsp_tdo_o;
    logic rsp_err_o;
    logic jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no;
    logic tap_tdo = 1'b0;

    int checks = 0;
    int errors = 0;

    jtag_shift_master #(.MaxLen(ML), .ClkDiv(CD)) dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_len_i   (req_len_i),
        .req_tdi_i   (req_tdi_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_tdo_o   (rsp_tdo_o),
        .rsp_err_o   (rsp_err_o),
        .jtag_tck_o  (jtag_tck_o),
        .jtag_tms_o  (jtag_tms_o),
        .jtag_tdi_o  (jtag_tdi_o),
        .jtag_trst_no(jtag_trst_no),
        .jtag_tdo_i  (tap_tdo)
    );

    always #5 clk = ~clk;

    // Behavioural TAP
    int ts = T_TLR;
    logic [4:0] ir = 5'd1;
    logic [4:0] isr = '0;
    logic [31:0] idr = '0;
    logic byp = 1'b0;
    logic tms_log[$];
    logic trst_log[$];

    function automatic int tap_next(int s, logic m);
        case (s)
            T_TLR:          return m ? T_TLR : T_RTI;
            T_RTI:          return m ? T_SDR : T_RTI;
            T_SDR:          return m ? T_SIR : T_CDR;
            T_CDR, T_SHDR:  return m ? T_E1DR : T_SHDR;
            T_E1DR:         return m ? T_UDR : T_PDR;
            T_PDR:          return m ? T_E2DR : T_PDR;
            T_E2DR:         return m ? T_UDR : T_SHDR;
            T_UDR, T_UIR:   return m ? T_SDR : T_RTI;
            T_SIR:          return m ? T_TLR : T_CIR;
            T_CIR, T_SHIR:  return m ? T_E1IR : T_SHIR;
            T_E1IR:         return m ? T_UIR : T_PIR;
            T_PIR:          return m ? T_E2IR : T_PIR;
            T_E2IR:         return m ? T_UIR : T_SHIR;
            default:        return T_TLR;
        endcase
    endfunction

    always @(posedge jtag_tck_o or negedge jtag_trst_no) begin
        if (!jtag_trst_no) begin
            ts = T_TLR;
            ir = 5'd1;
        end else begin
            case (ts)
                T_TLR:  ir = 5'd1;
                T_CDR: begin
                    idr = IDCODE[31:0];
                    byp = 1'b0;
                end
                T_SHDR: begin
                    if (ir == 5'd1) idr = {jtag_tdi_o, idr[31:1]};
                    else byp = jtag_tdi_o;
                end
                T_CIR:  isr = 5'b00001;
                T_SHIR: isr = {jtag_tdi_o, isr[4:1]};
                T_UIR:  ir = isr;
                default: ;
            endcase
            ts = tap_next(ts, jtag_tms_o);
        end
    end

    always @(negedge jtag_tck_o) begin
        if (ts == T_SHDR) tap_tdo = (ir == 5'd1) ? idr[0] : byp;
        else if (ts == T_SHIR) tap_tdo = isr[0];
        else tap_tdo = 1'b0;
    end

    always @(posedge jtag_tck_o) begin
        tms_log.push_back(jtag_tms_o);
        trst_log.push_back(jtag_trst_no);
    end

    task automatic do_cmd(input logic [1:0] op, input logic [LW-1:0] len,
                          input logic [63:0] tdi, input int hold,
                          output logic [63:0] tdo, output logic err,
                          output int lat, output int pulses,
                          output logic [127:0] tmsv, output logic stable);
        int n0;
        int k;
        k = 0;
        tdo = '0;
        err = 1'b0;
        tmsv = '0;
        stable = 1'b0;
        pulses = 0;
        while (!req_ready_o && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        n0 = tms_log.size();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i = op;
        req_len_i = len;
        req_tdi_i = tdi;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid_o) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout got valid=%0b required 1", rsp_valid_o);
        end
        tdo = rsp_tdo_o;
        err = rsp_err_o;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_tdo_o !== tdo ||
                rsp_err_o !== err || req_ready_o !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        pulses = tms_log.size() - n0;
        for (int i = 0; i < pulses && i < 128; i++) tmsv[i] = tms_log[n0 + i];
    endtask

    task automatic test_reset;
        int n0;
        int k;
        logic [5:0] tv;
        logic [5:0] rv;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
             req_ready_o, rsp_valid_o, rsp_err_o} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0100000",
                     {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
                      req_ready_o, rsp_valid_o, rsp_err_o});
        end
        checks++;
        if (rsp_tdo_o !== '0) begin
            errors++;
            $display("FAIL reset_tdo got %h required 0", rsp_tdo_o);
        end
        @(negedge clk);
        n0 = tms_log.size();
        rst_n = 1'b1;
        k = 0;
        while (!req_ready_o && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != 25) begin
            errors++;
            $display("FAIL reset_ready_cycle got %0d required 25", k);
        end
        checks++;
        if (tms_log.size() - n0 != 6) begin
            errors++;
            $display("FAIL reset_pulses got %0d required 6", tms_log.size() - n0);
        end
        tv = '0;
        rv = '0;
        for (int i = 0; i < 6 && n0 + i < tms_log.size(); i++) begin
            tv[i] = tms_log[n0 + i];
            rv[i] = trst_log[n0 + i];
        end
        checks++;
        if (tv !== 6'b011111) begin
            errors++;
            $display("FAIL reset_tms got %b required 011111", tv);
        end
        checks++;
        if (rv !== 6'b100000) begin
            errors++;
            $display("FAIL reset_trst got %b required 100000", rv);
        end
        checks++;
        if (ts != T_RTI) begin
            errors++;
            $display("FAIL reset_tap_state got %0d required %0d", ts, T_RTI);
        end
    endtask

    task automatic test_ir_idcode;
        logic [63:0] tdo;
        logic err, st;
        int lat, p;
        logic [127:0] tv;
        do_cmd(2'd1, 7'd5, 64'h1, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (lat != 45) begin
            errors++;
            $display("FAIL ir_latency got %0d required 45", lat);
        end
        checks++;
        if (p != 11) begin
            errors++;
            $display("FAIL ir_pulses got %0d required 11", p);
        end
        checks++;
        if (tv[10:0] !== 11'b01100000011) begin
            errors++;
            $display("FAIL ir_tms got %b required 01100000011", tv[10:0]);
        end
        checks++;
        if (tdo !== 64'h1 || err !== 1'b0) begin
            errors++;
            $display("FAIL ir_capture got %h/%b required 1/0", tdo, err);
        end
        checks++;
        if (ir !== 5'd1 || ts != T_RTI) begin
            errors++;
            $display("FAIL ir_tap got ir=%h st=%0d required 01/%0d", ir, ts, T_RTI);
        end
    endtask

    task automatic test_dr_idcode;
        logic [63:0] tdo;
        logic err, st;
        int lat, p;
        logic [127:0] tv;
        do_cmd(2'd0, 7'd32, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (tdo !== IDCODE) begin
            errors++;
            $display("FAIL dr_idcode got %h required %h", tdo, IDCODE);
        end
        checks++;
        if (p != 37 || lat != 149) begin
            errors++;
            $display("FAIL dr_timing got %0d/%0d required 37/149", p, lat);
        end
    endtask

    task automatic test_len_bounds;
        logic [63:0] tdo;
        logic [63:0] pat;
        logic err, st;
        int lat, p;
        logic [127:0] tv;
        do_cmd(2'd0, 7'd1, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (p != 6 || lat != 25) begin
            errors++;
            $display("FAIL len1_timing got %0d/%0d required 6/25", p, lat);
        end
        checks++;
        if (tv[5:0] !== 6'b011001) begin
            errors++;
            $display("FAIL len1_tms got %b required 011001", tv[5:0]);
        end
        checks++;
        if (tdo !== 64'h1) begin
            errors++;
            $display("FAIL len1_tdo got %h required 1", tdo);
        end
        do_cmd(2'd1, 7'd5, 64'h1f, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (ir !== 5'h1f) begin
            errors++;
            $display("FAIL bypass_ir got %h required 1f", ir);
        end
        pat = 64'hA5C3_0F1E_9687_B4D2;
        do_cmd(2'd0, 7'd64, pat, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (tdo !== 64'h4B86_1E3D_2D0F_69A4) begin
            errors++;
            $display("FAIL maxlen_bypass got %h required 4b861e3d2d0f69a4", tdo);
        end
        checks++;
        if (p != 69 || lat != 277) begin
            errors++;
            $display("FAIL maxlen_timing got %0d/%0d required 69/277", p, lat);
        end
    endtask

    task automatic test_errors;
        logic [1:0] ops [4];
        logic [LW-1:0] lens [4];
        logic [63:0] tdo;
        logic err, st;
        int lat, p;
        logic [127:0] tv;
        ops = '{2'd0, 2'd0, 2'd1, 2'd3};
        lens = '{7'd0, 7'd65, 7'd0, 7'd5};
        for (int i = 0; i < 4; i++) begin
            do_cmd(ops[i], lens[i], 64'hFF, 0, tdo, err, lat, p, tv, st);
            checks++;
            if (err !== 1'b1 || lat != 1 || p != 0 || tdo !== '0) begin
                errors++;
                $display("FAIL err_case%0d got err=%b lat=%0d p=%0d tdo=%h required 1/1/0/0",
                         i, err, lat, p, tdo);
            end
        end
        do_cmd(2'd2, 7'd0, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (err !== 1'b0 || tdo !== '0 || lat != 25 || p != 6) begin
            errors++;
            $display("FAIL tap_reset_op got err=%b tdo=%h lat=%0d p=%0d required 0/0/25/6",
                     err, tdo, lat, p);
        end
        checks++;
        if (ir !== 5'd1 || ts != T_RTI) begin
            errors++;
            $display("FAIL tap_reset_state got ir=%h st=%0d required 01/%0d", ir, ts, T_RTI);
        end
        do_cmd(2'd0, 7'd32, 64'h0, 10, tdo, err, lat, p, tv, st);
        checks++;
        if (st !== 1'b1 || tdo !== IDCODE) begin
            errors++;
            $display("FAIL backpressure got stable=%b tdo=%h required 1/%h", st, tdo, IDCODE);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] tdo;
        logic err, st;
        int lat, p;
        logic [127:0] tv;
        @(negedge clk);
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_rsp_ready got valid=%b ready=%b required 0/1",
                     rsp_valid_o, req_ready_o);
        end
        rsp_ready_i = 1'b0;
        do_cmd(2'd3, 7'd1, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || jtag_tck_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got ready=%b valid=%b tck=%b required 1/0/0",
                     req_ready_o, rsp_valid_o, jtag_tck_o);
        end
        do_cmd(2'd0, 7'd32, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (tdo !== IDCODE || lat != 149 || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got tdo=%h lat=%0d required %h/149", tdo, lat, IDCODE);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] tdo;
        logic err, st;
        int lat, p, k, n0;
        logic [127:0] tv;
        n0 = tms_log.size();
        @(negedge clk);
        req_valid_i = 1'b1;
        req_op_i = 2'd0;
        req_len_i = 7'd32;
        req_tdi_i = '0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (32) @(posedge clk);
        #2;
        checks++;
        if (tms_log.size() - n0 != 8) begin
            errors++;
            $display("FAIL mid_progress got %0d required 8", tms_log.size() - n0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
             req_ready_o, rsp_valid_o, rsp_err_o} !== 7'b0100000 ||
            rsp_tdo_o !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b/%h required 0100000/0",
                     {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
                      req_ready_o, rsp_valid_o, rsp_err_o}, rsp_tdo_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (!req_ready_o && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (k != 25 || ts != T_RTI) begin
            errors++;
            $display("FAIL mid_autorst got %0d/%0d required 25/%0d", k, ts, T_RTI);
        end
        do_cmd(2'd0, 7'd32, 64'h0, 0, tdo, err, lat, p, tv, st);
        checks++;
        if (tdo !== IDCODE) begin
            errors++;
            $display("FAIL mid_idcode got %h required %h", tdo, IDCODE);
        end
    endtask

    initial begin
        test_reset();
        test_ir_idcode();
        test_dr_idcode();
        test_len_bounds();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
